// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the IF/LS memory port arbiter
package mem_arb_pkg;
    localparam int ADDR_W_DFLT = 32;
    localparam int DATA_W_DFLT = 32;
    localparam int BE_W        = DATA_W_DFLT / 8;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;
endpackage

// File: rtl/arb_starve_select.sv
// rtl/arb_starve_select.sv - LS-priority winner selection with a bounded fetch-starvation counter
module arb_starve_select #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_valid,
    input  logic ls_valid,
    input  logic grant_fire,
    output logic grant_ls,
    output logic grant_if
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved  = (starve_cnt == CW'(STARVE_MAX));
    assign grant_ls = ls_valid && !(if_valid && starved);
    assign grant_if = if_valid && !grant_ls;

    // Counts LS grants that bypassed a waiting fetch; any other grant clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_fire) begin
            if (grant_ls && if_valid) begin
                starve_cnt <= starved ? starve_cnt : starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and load/store
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DFLT,
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                ls_req_valid,
    input  logic                ls_req_we,
    input  logic [DATA_W/8-1:0] ls_req_be,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    output logic                ls_req_ready,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [DATA_W/8-1:0] mem_req_be,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                busy,
    output logic                protocol_err
);
    state_e state, state_nxt;
    owner_e owner;
    logic   grant_ls, grant_if, accept;

    assign accept = (state == IDLE) && (grant_ls || grant_if);

    arb_starve_select #(.STARVE_MAX(STARVE_MAX)) u_select (
        .clk        (clk),
        .reset      (reset),
        .if_valid   (if_req_valid),
        .ls_valid   (ls_req_valid),
        .grant_fire (accept),
        .grant_ls   (grant_ls),
        .grant_if   (grant_if)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = ISSUE;
            ISSUE:   if (mem_req_ready) state_nxt = WAIT;
            WAIT:    if (mem_rsp_valid) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Readies are gated by reset so nothing is offered while reset is held.
    always_comb begin
        if_req_ready  = reset && (state == IDLE) && grant_if;
        ls_req_ready  = reset && (state == IDLE) && grant_ls;
        mem_req_valid = (state == ISSUE);
        if_rsp_valid  = (state == WAIT) && mem_rsp_valid && (owner == OWN_IF);
        ls_rsp_valid  = (state == WAIT) && mem_rsp_valid && (owner == OWN_LS);
        if_rsp_data   = mem_rsp_data;
        ls_rsp_data   = mem_rsp_data;
        busy          = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner         <= OWN_IF;
            mem_req_we    <= 1'b0;
            mem_req_be    <= '0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
        end else if (accept) begin
            if (grant_ls) begin
                owner         <= OWN_LS;
                mem_req_we    <= ls_req_we;
                mem_req_be    <= ls_req_be;
                mem_req_addr  <= ls_req_addr;
                mem_req_wdata <= ls_req_wdata;
            end else begin
                owner         <= OWN_IF;
                mem_req_we    <= 1'b0;
                mem_req_be    <= '1;
                mem_req_addr  <= if_req_addr;
                mem_req_wdata <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            protocol_err <= 1'b0;
        end else if (mem_rsp_valid && (state != WAIT)) begin
            protocol_err <= 1'b1;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory of the RISC-V core between two requesters: instruction fetch (IF) and the load/store unit (LS).
- Sits between the CPU pipeline and the memory model; the CPU top instantiates it in place of separate instruction and data ports.
- Allows one outstanding transaction at a time.
- LS has priority; a starvation limit guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 4, maximum consecutive LS grants while IF is waiting; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch address (pc).
- if_req_ready  out  1  fetch request accepted this cycle.
- if_rsp_valid  out  1  fetch data valid, one-cycle pulse.
- if_rsp_data  out  DATA_W  instruction word.
- ls_req_valid  in  1  load/store request.
- ls_req_we  in  1  1 = store.
- ls_req_be  in  DATA_W/8  byte enables.
- ls_req_addr  in  ADDR_W  data address.
- ls_req_wdata  in  DATA_W  store data.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_rsp_valid  out  1  load data or store acknowledge, one-cycle pulse.
- ls_rsp_data  out  DATA_W  load data; don't-care for stores.
- mem_req_valid  out  1  request to memory.
- mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata  out  1 / DATA_W/8 / ADDR_W / DATA_W  latched request fields.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  memory response; issued for reads and writes.
- mem_rsp_data  in  DATA_W  read data.
- busy  out  1  state != IDLE.
- protocol_err  out  1  sticky: mem_rsp_valid seen outside WAIT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; starve_cnt = 0; owner = OWN_IF.
  - All latched request fields = 0.
  - All valid/ready outputs = 0; busy = 0; protocol_err = 0.
  - An in-flight response is discarded; requesters must re-issue after reset.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Winner chosen combinationally; only the winner's req_ready = 1 when it is valid.
  - On the valid&ready edge: latch owner, we, be, addr, wdata; go to ISSUE.
  - IF requests latch we = 0, be = all-ones, wdata = 0.
- ISSUE:
  - mem_req_valid = 1 with latched fields held stable.
  - On mem_req_ready = 1, go to WAIT.
- WAIT:
  - mem_rsp_valid is routed combinationally in the same cycle: owner's rsp_valid = 1, rsp_data = mem_rsp_data.
  - Non-owner rsp_valid = 0.
  - Next state is IDLE.
- Minimum turnaround:
  - Accept at cycle T, mem_req_valid at T+1 (ready = 1), response at T+2.
  - Next accept no earlier than T+3.
- Arbitration:
  - Only LS valid → LS. Only IF valid → IF.
  - Both valid: LS wins unless starve_cnt == STARVE_MAX, in which case IF wins.
- starve_cnt, updated only on grants:
  - LS grant while if_req_valid = 1: increment, saturating at STARVE_MAX.
  - LS grant with if_req_valid = 0: clear.
  - Any IF grant: clear.
- Requests arriving in ISSUE/WAIT see req_ready = 0; requesters hold valid and fields stable until accepted.
- Deasserting valid before acceptance is legal; no state changes.
- mem_rsp_valid in IDLE or ISSUE is ignored for routing and sets protocol_err, which stays set until reset.
- No address alignment checks; fields are passed through unchanged.

Decomposition:
- Package mem_arb_pkg:
  - owner_e {OWN_IF, OWN_LS}.
  - state_e {IDLE, ISSUE, WAIT}.
  - localparam BE_W = DATA_W/8.
- One sub-module, arb_starve_select: winner selection plus starve_cnt register.
  - Inputs: clk, reset, if_valid, ls_valid, grant_fire.
  - Outputs: grant_ls, grant_if.
- The top module holds the FSM, latches and response routing.

Test Plan:
- Reset mid-transaction:
  - Stimulus: assert reset=0 while in WAIT.
  - Response: busy = 0 and all ready/valid = 0 immediately; no rsp pulse for the lost request; protocol_err = 0.
- Single fetch:
  - Stimulus: if_req_addr = 0x0000_0010; memory ready immediately; response one cycle later with 0x00500F93.
  - Response: if_rsp_valid pulses exactly once with 0x00500F93; accept-to-response is 2 cycles; ls_rsp_valid stays 0.
- Store:
  - Stimulus: ls store at addr 0x100, be = 4'b0011, wdata = 0xDEADBEEF; memory ready is held 0 for 3 cycles.
  - Response: mem_req_* fields stay stable throughout; ls_rsp_valid pulses once after the ack.
- Simultaneous requests:
  - Stimulus: IF and LS both continuously valid, STARVE_MAX = 4.
  - Response: grant order is LS, LS, LS, LS, IF, LS, …
- Stray response:
  - Stimulus: mem_rsp_valid pulsed while in IDLE.
  - Response: protocol_err = 1 and stays set; no rsp_valid to either requester.
